// File: rtl/f_lane_pkg.sv
// Shared defaults and helpers for the falling-block lane engine.
// Optional statistics counters are enabled with F_LANE_STATS_EN.
package f_lane_pkg;

    localparam int unsigned DEF_HW     = 10;
    localparam int unsigned DEF_BEAT_W = 7;
    localparam int unsigned DEF_TOP    = 120;
    localparam int unsigned DEF_BOTTOM = 720;
    localparam int unsigned DEF_HIT_LO = 600;
    localparam int unsigned DEF_HIT_HI = 680;
    localparam int unsigned CNT_W      = 8;

    // Upper bounds of the flat slot vector that slot_sel can address.
    localparam int unsigned MAX_SLOT = 8;
    localparam int unsigned MAX_HW   = 16;
    localparam int unsigned FLAT_W   = MAX_SLOT * MAX_HW;

    localparam logic [127:0] DEF_SPAWN_MASK =
        (128'd1 << 4)  | (128'd1 << 22) | (128'd1 << 28) |
        (128'd1 << 34) | (128'd1 << 46) | (128'd1 << 58) |
        (128'd1 << 64) | (128'd1 << 70) | (128'd1 << 88);

    // Extract slot idx of width hw from a zero-extended flat vector.
    function automatic logic [MAX_HW-1:0] slot_sel(input logic [FLAT_W-1:0] h,
                                                   input int unsigned idx,
                                                   input int unsigned hw = DEF_HW);
        return MAX_HW'(h >> (idx * hw));
    endfunction

endpackage

// File: rtl/f_slot_pick.sv
// Combinational slot selection: lowest free slot and best hit candidate
// (largest height inside the hit window, ties to the lowest index).
module f_slot_pick
    import f_lane_pkg::*;
#(
    parameter  int unsigned NSLOT  = 4,
    parameter  int unsigned HW     = DEF_HW,
    parameter  int unsigned HIT_LO = DEF_HIT_LO,
    parameter  int unsigned HIT_HI = DEF_HIT_HI,
    localparam int unsigned IDX_W  = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic [NSLOT-1:0]    slot_v,
    input  logic [NSLOT*HW-1:0] slot_h,
    output logic [IDX_W-1:0]    free_idx,
    output logic                any_free,
    output logic [IDX_W-1:0]    cand_idx,
    output logic                cand_found
);

    logic [FLAT_W-1:0] h_flat;
    logic [HW-1:0]     h_arr [NSLOT];
    logic [HW-1:0]     best_h;

    assign h_flat = FLAT_W'(slot_h);

    for (genvar i = 0; i < NSLOT; i++) begin : g_unpack
        assign h_arr[i] = HW'(slot_sel(h_flat, i, HW));
    end

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!slot_v[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    // Strict greater-than keeps the lowest index on equal heights.
    always_comb begin
        cand_idx   = '0;
        cand_found = 1'b0;
        best_h     = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_v[i] && (h_arr[i] >= HW'(HIT_LO)) && (h_arr[i] <= HW'(HIT_HI)) &&
                (!cand_found || (h_arr[i] > best_h))) begin
                cand_idx   = IDX_W'(i);
                cand_found = 1'b1;
                best_h     = h_arr[i];
            end
        end
    end

endmodule

// File: rtl/f_lane_blocks.sv
// Per-lane falling-block engine: beat-driven spawn, tick-driven motion, key judging.
// Define F_LANE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module f_lane_blocks
    import f_lane_pkg::*;
#(
    parameter int unsigned NSLOT  = 4,
    parameter int unsigned HW     = DEF_HW,
    parameter int unsigned BEAT_W = DEF_BEAT_W,
    parameter int unsigned TOP    = DEF_TOP,
    parameter int unsigned BOTTOM = DEF_BOTTOM,
    parameter int unsigned STEP   = 1,
    parameter int unsigned HIT_LO = DEF_HIT_LO,
    parameter int unsigned HIT_HI = DEF_HIT_HI,
    parameter logic [(1 << BEAT_W)-1:0] SPAWN_MASK = DEF_SPAWN_MASK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic                freeze,
    input  logic                tick,
    input  logic [BEAT_W-1:0]   beat_cnt,
    input  logic                key_hit,
    output logic [NSLOT*HW-1:0] block_h,
    output logic [NSLOT-1:0]    block_v,
    output logic                hit,
    output logic [NSLOT-1:0]    miss,
    output logic                overflow
`ifdef F_LANE_STATS_EN
    ,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
`endif
);

    localparam int unsigned IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    if ((NSLOT < 1) || (NSLOT > MAX_SLOT) || (HW > MAX_HW)) begin : g_bad_size
        $error("f_lane_blocks: NSLOT must be 1..8 and HW at most 16");
    end
    if (!((BOTTOM + STEP) < (1 << HW))) begin : g_bad_range
        $error("f_lane_blocks: BOTTOM+STEP must fit in HW bits");
    end
    if (!((TOP < HIT_LO) && (HIT_LO <= HIT_HI) && (HIT_HI < BOTTOM))) begin : g_bad_window
        $error("f_lane_blocks: need TOP < HIT_LO <= HIT_HI < BOTTOM");
    end

    logic [HW-1:0]       h_q [NSLOT];
    logic [HW-1:0]       h_d [NSLOT];
    logic [NSLOT-1:0]    v_q, v_d;
    logic [NSLOT-1:0]    miss_q, miss_d;
    logic                hit_q, hit_d;
    logic                ovf_q, ovf_d;
    logic [BEAT_W-1:0]   pre_beat_q, pre_beat_d;

    logic [NSLOT*HW-1:0] h_flat;
    logic [IDX_W-1:0]    free_idx, cand_idx;
    logic                any_free, cand_found;
    logic                beat_add, spawn_req, hit_sel;
    logic [HW:0]         sum;

    for (genvar i = 0; i < NSLOT; i++) begin : g_pack
        assign h_flat[i*HW +: HW] = h_q[i];
    end

    assign block_h  = h_flat;
    assign block_v  = v_q;
    assign hit      = hit_q;
    assign miss     = miss_q;
    assign overflow = ovf_q;

    f_slot_pick #(
        .NSLOT  (NSLOT),
        .HW     (HW),
        .HIT_LO (HIT_LO),
        .HIT_HI (HIT_HI)
    ) u_pick (
        .slot_v     (v_q),
        .slot_h     (h_flat),
        .free_idx   (free_idx),
        .any_free   (any_free),
        .cand_idx   (cand_idx),
        .cand_found (cand_found)
    );

    // Selection uses pre-cycle state, so frees in this cycle never become spawn targets.
    always_comb begin
        beat_add   = (beat_cnt > pre_beat_q);
        spawn_req  = beat_add & SPAWN_MASK[beat_cnt] & ~freeze;
        hit_sel    = key_hit & ~freeze & cand_found;

        pre_beat_d = beat_cnt;
        v_d        = v_q;
        h_d        = h_q;
        hit_d      = 1'b0;
        miss_d     = '0;
        ovf_d      = 1'b0;
        sum        = '0;

        if (hit_sel) begin
            v_d[cand_idx] = 1'b0;
            h_d[cand_idx] = HW'(BOTTOM);
            hit_d         = 1'b1;
        end

        if (tick && !freeze) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (v_q[i] && !(hit_sel && (cand_idx == IDX_W'(i)))) begin
                    sum = {1'b0, h_q[i]} + (HW+1)'(STEP);
                    if (sum >= (HW+1)'(BOTTOM)) begin
                        v_d[i]    = 1'b0;
                        h_d[i]    = HW'(BOTTOM);
                        miss_d[i] = 1'b1;
                    end else begin
                        h_d[i] = HW'(sum);
                    end
                end
            end
        end

        if (spawn_req) begin
            if (any_free) begin
                v_d[free_idx] = 1'b1;
                h_d[free_idx] = HW'(TOP);
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (restart) begin
            pre_beat_d = '0;
            v_d        = '0;
            hit_d      = 1'b0;
            miss_d     = '0;
            ovf_d      = 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                h_d[i] = HW'(BOTTOM);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_beat_q <= '0;
            v_q        <= '0;
            hit_q      <= 1'b0;
            miss_q     <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                h_q[i] <= HW'(BOTTOM);
            end
        end else begin
            pre_beat_q <= pre_beat_d;
            v_q        <= v_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < NSLOT; i++) begin
                h_q[i] <= h_d[i];
            end
        end
    end

`ifdef F_LANE_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W:0]   miss_sum;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Counters move together with the pulses they count.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        miss_sum   = {1'b0, miss_cnt_q} + (CNT_W+1)'($countones(miss_d));
        if (hit_d && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (miss_sum[CNT_W]) begin
            miss_cnt_d = '1;
        end else begin
            miss_cnt_d = CNT_W'(miss_sum);
        end
        if (restart) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

endmodule

// File: doc/f_lane_blocks.md
Name: f_lane_blocks

Overview:
- Per-lane falling-block engine for the piano game; parametrised successor of the single-block lane generator.
- Tracks up to NSLOT concurrent blocks per lane.
- Spawns blocks on beat-count increments selected by a per-beat spawn mask, advances them on a tick strobe, and judges key presses inside a hit window.
- Sits between the beat counter and the VGA block renderer / score logic; one instance per key lane.

Parameters:
- NSLOT, 4, number of concurrent block slots in the lane (1..8)
- HW, 10, height/coordinate width in bits
- BEAT_W, 7, beat counter width
- TOP, 120, spawn height
- BOTTOM, 720, off-screen height; also the parked value for an empty slot
- STEP, 1, pixels added per tick
- HIT_LO, 600, inclusive lower bound of the hit window
- HIT_HI, 680, inclusive upper bound of the hit window
- SPAWN_MASK, 2**BEAT_W bits, bit b set = spawn on beat b; default has bits 4,22,28,34,46,58,64,70,88 set

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- restart  in  1  game restart; synchronous, same effect as rst
- freeze  in  1  pause/endgame; holds all motion, spawning and judging
- tick  in  1  one-cycle motion strobe (replaces the divided clock)
- beat_cnt  in  BEAT_W  current beat number
- key_hit  in  1  one-cycle key-press pulse for this lane
- block_h  out  NSLOT*HW  slot heights, slot i at [i*HW +: HW]
- block_v  out  NSLOT  slot valid flags
- hit  out  1  one-cycle pulse: a block was judged hit
- miss  out  NSLOT  one-cycle per-slot pulse: block left the screen unhit
- overflow  out  1  one-cycle pulse: spawn dropped, no free slot

Behaviour:
- Single clock. rst is synchronous and active-high. All outputs are registered; 1-cycle latency from input to output.
- Reset/restart state: block_v=0, every block_h=BOTTOM, hit=0, miss=0, overflow=0, pre_beat=0. Priority: rst > restart > normal operation.
- Beat edge:
  - pre_beat register captures beat_cnt every cycle.
  - beat_add = (beat_cnt > pre_beat). A wrap or decrease never spawns.
  - spawn_req = beat_add & SPAWN_MASK[beat_cnt] & ~freeze.
  - pre_beat updates during freeze as well, so beats missed during freeze never spawn later.
- Spawn:
  - Target is the lowest-index slot with block_v=0, sampled before this cycle's frees.
  - Target slot gets v=1, h=TOP.
  - No free slot: drop the spawn, overflow=1 for one cycle.
  - A newly spawned block does not move in its spawn cycle.
- Judge (key_hit & ~freeze):
  - Candidates: valid slots with HIT_LO <= h <= HIT_HI, using pre-move heights.
  - Pick the largest h; ties go to the lowest index.
  - Clear the picked slot (v=0, h=BOTTOM), hit=1.
  - No candidate: no effect, hit=0.
  - The hit slot is not moved and cannot be a spawn target in the same cycle.
- Motion (tick & ~freeze), for each valid slot not hit this cycle:
  - Compute sum = h+STEP in HW+1 bits.
  - If sum >= BOTTOM: v=0, h=BOTTOM, miss[i]=1.
  - Otherwise h = sum.
  - Several miss bits may assert in the same cycle.
- freeze=1: heights, valids and pre-move state held; hit/miss/overflow forced 0.
- Invalid slots always read block_h=BOTTOM, so the renderer treats BOTTOM as hidden.
- Elaboration checks: BOTTOM+STEP < 2**HW; TOP < HIT_LO <= HIT_HI < BOTTOM.

Optional Feature:
- Macro: F_LANE_STATS_EN.
- Defined: adds outputs hit_cnt and miss_cnt, 8 bits each, registered.
  - hit_cnt increments by 1 per hit pulse.
  - miss_cnt increments by popcount(miss) per cycle.
  - Both saturate at 255 and clear on rst/restart.
- Undefined: ports absent, no counters. All other behaviour identical.

Decomposition:
- Package f_lane_pkg holds:
  - default HW, BEAT_W, TOP, BOTTOM, HIT_LO, HIT_HI
  - default SPAWN_MASK constant
  - function slot_sel(h, idx) for packed-vector slicing
- Sub-module f_slot_pick: combinational, parametrised by NSLOT/HW. Outputs:
  - lowest-free index plus any_free
  - best hit candidate index plus cand_found
- Top level keeps all state registers.

Test Plan:
- Spawn: rst 2 cycles, then beat_cnt 3→4 -> next cycle block_v=0001, slot0 h=120. beat_cnt 4→5 -> no spawn.
- Motion and miss: one block, 600 ticks -> h=720 edge reached on the 600th tick, miss=0001 for one cycle, block_v=0, h=720.
- Hit window: blocks at h=650 (slot0) and h=610 (slot1), key_hit -> slot0 cleared, hit=1, slot1 at 610 (+STEP if tick same cycle). key_hit with only h=590 -> hit=0, nothing cleared.
- Overflow: NSLOT=4, fill 4 slots via spawns at 4,22,28,34 with no ticks, then beat 46 -> overflow=1, slots unchanged. Hit one slot, then beat 58 -> spawn into the freed lowest index.
- Freeze: freeze=1 during beat 22 and tick/key_hit pulses -> no spawn, no motion, no pulses. Release freeze -> no delayed spawn for beat 22.
- Restart mid-game: 3 valid blocks, restart=1 for one cycle -> next cycle block_v=0, all h=720, and, with F_LANE_STATS_EN, hit_cnt=miss_cnt=0.
